// File: rtl/idiv53_share_ctrl.sv
// idiv53_share_ctrl: round-robin controller sharing one idiv53 divider
// between NREQ requesters. Latches operands, pulses the divider start,
// waits for ready (with watchdog) and returns the response to the owner.
module idiv53_share_ctrl #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 63
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*53-1:0] i_req_divident,
  input  logic [NREQ*53-1:0] i_req_divisor,
  output logic [NREQ-1:0]   o_resp_valid,
  output logic [104:0]      o_resp_result,
  output logic [6:0]        o_resp_lshift,
  output logic              o_resp_overflow,
  output logic              o_resp_zero_resid,
  output logic              o_resp_timeout,
  output logic              o_div_ena,
  output logic [52:0]       o_div_divident,
  output logic [52:0]       o_div_divisor,
  input  logic              i_div_rdy,
  input  logic [104:0]      i_div_result,
  input  logic [6:0]        i_div_lshift,
  input  logic              i_div_overflow,
  input  logic              i_div_zero_resid,
  output logic              o_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [WW-1:0]   watchdog;
  logic [52:0]     opa, opb;
  logic [104:0]    res_result;
  logic [6:0]      res_lshift;
  logic            res_overflow;
  logic            res_zero_resid;
  logic            res_timeout;

  logic            grant_hit;
  logic [PW-1:0]   grant_idx;
  logic [52:0]     sel_divident;
  logic [52:0]     sel_divisor;
  logic            hs;
  logic            wd_expired;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned idx;
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!grant_hit && i_req_valid[idx]) begin
        grant_hit = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    sel_divident = i_req_divident[int'(grant_idx)*53 +: 53];
    sel_divisor  = i_req_divisor[int'(grant_idx)*53 +: 53];
    hs           = (state == S_IDLE) && grant_hit;
    wd_expired   = (watchdog == WW'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; div-by-zero skips the divider entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hs) state_nxt = (sel_divisor == '0) ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (i_div_rdy || wd_expired) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, watchdog, response capture, rr pointer.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      rr_ptr         <= '0;
      owner          <= '0;
      watchdog       <= '0;
      opa            <= '0;
      opb            <= '0;
      res_result     <= '0;
      res_lshift     <= '0;
      res_overflow   <= 1'b0;
      res_zero_resid <= 1'b0;
      res_timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            owner <= grant_idx;
            opa   <= sel_divident;
            opb   <= sel_divisor;
            if (sel_divisor == '0) begin
              res_result     <= '1;
              res_lshift     <= '0;
              res_overflow   <= 1'b1;
              res_zero_resid <= 1'b0;
              res_timeout    <= 1'b0;
            end
          end
        end
        S_ISSUE: watchdog <= '0;
        S_WAIT: begin
          watchdog <= watchdog + 1'b1;
          // rdy takes priority over a simultaneous watchdog expiry
          if (i_div_rdy) begin
            res_result     <= i_div_result;
            res_lshift     <= i_div_lshift;
            res_overflow   <= i_div_overflow;
            res_zero_resid <= i_div_zero_resid;
            res_timeout    <= 1'b0;
          end else if (wd_expired) begin
            res_result     <= '0;
            res_lshift     <= '0;
            res_overflow   <= 1'b1;
            res_zero_resid <= 1'b0;
            res_timeout    <= 1'b1;
          end
        end
        S_RESP: rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode from state and registered datapath.
  always_comb begin
    o_req_ready       = hs ? (NREQ'(1) << grant_idx) : '0;
    o_resp_valid      = (state == S_RESP) ? (NREQ'(1) << owner) : '0;
    o_div_ena         = (state == S_ISSUE);
    o_busy            = (state != S_IDLE);
    o_div_divident    = opa;
    o_div_divisor     = opb;
    o_resp_result     = res_result;
    o_resp_lshift     = res_lshift;
    o_resp_overflow   = res_overflow;
    o_resp_zero_resid = res_zero_resid;
    o_resp_timeout    = res_timeout;
  end

endmodule

// File: tb/tb_idiv53_share_ctrl.sv
// Directed bench for idiv53_share_ctrl with a behavioural idiv53 model
// (quotient result, fixed lshift of 5, programmable latency or hang).
module tb_idiv53_share_ctrl;

  logic          clk;
  logic          nrst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [105:0]  req_divident;
  logic [105:0]  req_divisor;
  logic [1:0]    resp_valid;
  logic [104:0]  resp_result;
  logic [6:0]    resp_lshift;
  logic          resp_overflow;
  logic          resp_zero_resid;
  logic          resp_timeout;
  logic          div_ena;
  logic [52:0]   div_divident;
  logic [52:0]   div_divisor;
  logic          div_rdy;
  logic [104:0]  div_result;
  logic [6:0]    div_lshift;
  logic          div_overflow;
  logic          div_zero_resid;
  logic          busy;

  int tests = 0;
  int fails = 0;

  // divider model state
  logic          mdl_rdy = 1'b0;
  int            mdl_cnt = 0;
  int            mdl_lat = 15;
  bit            mdl_hang = 1'b0;
  logic [52:0]   mdl_a = '0;
  logic [52:0]   mdl_b = '0;
  logic          spur_rdy = 1'b0;
  logic [104:0]  all_ones;

  idiv53_share_ctrl #(.NREQ(2), .TIMEOUT(63)) dut (
    .i_clk             (clk),
    .i_nrst            (nrst),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_divident    (req_divident),
    .i_req_divisor     (req_divisor),
    .o_resp_valid      (resp_valid),
    .o_resp_result     (resp_result),
    .o_resp_lshift     (resp_lshift),
    .o_resp_overflow   (resp_overflow),
    .o_resp_zero_resid (resp_zero_resid),
    .o_resp_timeout    (resp_timeout),
    .o_div_ena         (div_ena),
    .o_div_divident    (div_divident),
    .o_div_divisor     (div_divisor),
    .i_div_rdy         (div_rdy),
    .i_div_result      (div_result),
    .i_div_lshift      (div_lshift),
    .i_div_overflow    (div_overflow),
    .i_div_zero_resid  (div_zero_resid),
    .o_busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rdy is sampled high mdl_lat edges after the edge that samples ena
  always @(posedge clk) begin
    mdl_rdy <= 1'b0;
    if (div_ena) begin
      if (!mdl_hang) mdl_cnt <= mdl_lat - 1;
      mdl_a <= div_divident;
      mdl_b <= div_divisor;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mdl_rdy <= 1'b1;
    end
  end

  assign div_rdy        = mdl_rdy | spur_rdy;
  assign div_result     = (mdl_b == '0) ? '0 : 105'(mdl_a / mdl_b);
  assign div_lshift     = 7'd5;
  assign div_overflow   = 1'b0;
  assign div_zero_resid = (mdl_b != '0) && ((mdl_a % mdl_b) == '0);

  // Issue one request from requester k and observe until its response.
  task automatic run_op(input int k, input logic [52:0] a, input logic [52:0] b,
                        output int ena_at, output int ena_cnt, output int resp_at,
                        output logic [1:0] rv, output logic [104:0] res,
                        output logic [6:0] ls, output logic ov, output logic zr,
                        output logic to);
    int w;
    ena_at = -1; ena_cnt = 0; resp_at = -1;
    rv = '0; res = '0; ls = '0; ov = 1'b0; zr = 1'b0; to = 1'b0;
    @(negedge clk);
    req_divident[k*53 +: 53] = a;
    req_divisor[k*53 +: 53]  = b;
    req_valid[k] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[k] && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready[k]) begin
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    for (int n = 1; n <= 150 && resp_at < 0; n++) begin
      @(negedge clk);
      if (div_ena) begin
        ena_cnt++;
        if (ena_at < 0) ena_at = n;
      end
      if (resp_valid != '0) begin
        resp_at = n; rv = resp_valid; res = resp_result; ls = resp_lshift;
        ov = resp_overflow; zr = resp_zero_resid; to = resp_timeout;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || req_ready !== 2'b00 || resp_valid !== 2'b00 || div_ena !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: busy=%b ready=%b resp=%b ena=%b want 0", busy, req_ready, resp_valid, div_ena);
    end
    tests++;
    if (div_divident !== '0 || div_divisor !== '0 || resp_result !== '0 ||
        resp_lshift !== '0 || resp_overflow !== 1'b0 || resp_timeout !== 1'b0 || resp_zero_resid !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: dvd=%0h dvs=%0h res=%0h want all 0", div_divident, div_divisor, resp_result);
    end
    nrst = 1'b1;
    @(negedge clk);
    req_valid = 2'b11; #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL reset_rr_both: got %b want 01", req_ready);
    end
    req_valid = 2'b10; #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL reset_rr_one: got %b want 10", req_ready);
    end
    req_valid = 2'b00; #1;
  endtask

  task automatic test_single();
    int ea, ec, ra; logic [1:0] rv; logic [104:0] res; logic [6:0] ls; logic ov, zr, to;
    mdl_lat = 15;
    run_op(0, 53'h10_0000_0000_0000, 53'h08_0000_0000_0000, ea, ec, ra, rv, res, ls, ov, zr, to);
    tests++;
    if (ea !== 1 || ec !== 1) begin
      fails++;
      $display("FAIL single_ena: at=%0d cnt=%0d want at=1 cnt=1", ea, ec);
    end
    tests++;
    if (ra !== 17 || rv !== 2'b01) begin
      fails++;
      $display("FAIL single_resp: at=%0d strobe=%b want 17 01", ra, rv);
    end
    tests++;
    if (res !== 105'd2 || ls !== 7'd5 || ov !== 1'b0 || zr !== 1'b1 || to !== 1'b0) begin
      fails++;
      $display("FAIL single_data: res=%0h ls=%0d ov=%b zr=%b to=%b want 2 5 0 1 0", res, ls, ov, zr, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] grants [4];
    int gcyc [4];
    int g, r;
    g = 0; r = 0;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    mdl_lat = 15;
    req_divident = {53'd77, 53'd1000};
    req_divisor  = {53'd7, 53'd10};
    req_valid = 2'b11;
    for (int n = 0; n < 200 && r < 4; n++) begin
      if (n > 0) @(negedge clk); else #1;
      if (req_ready != 2'b00) begin
        tests++;
        if (req_ready !== 2'b01 && req_ready !== 2'b10) begin
          fails++;
          $display("FAIL b2b_onehot: got %b", req_ready);
        end
        if (g < 4) begin grants[g] = req_ready; gcyc[g] = n; end
        g++;
      end
      if (resp_valid != 2'b00) begin
        tests++;
        if (req_ready !== 2'b00 || r >= g || resp_valid !== grants[r]) begin
          fails++;
          $display("FAIL b2b_owner: resp=%b ready=%b want resp=%b ready=00", resp_valid, req_ready, (r < g) ? grants[r] : 2'b00);
        end
        tests++;
        if (resp_result !== ((resp_valid == 2'b01) ? 105'd100 : 105'd11) || resp_zero_resid !== 1'b1) begin
          fails++;
          $display("FAIL b2b_data: resp=%b res=%0d zr=%b", resp_valid, resp_result, resp_zero_resid);
        end
        r++;
        if (r == 4) req_valid = 2'b00;
      end
    end
    req_valid = 2'b00;
    tests++;
    if (r !== 4 || g !== 4 || grants[0] !== 2'b01 || grants[1] !== 2'b10 ||
        grants[2] !== 2'b01 || grants[3] !== 2'b10) begin
      fails++;
      $display("FAIL b2b_order: resps=%0d grants=%0d want 4 4 alternating 01,10", r, g);
    end
    tests++;
    if (g == 4 && (gcyc[1] - gcyc[0] !== 18 || gcyc[2] - gcyc[1] !== 18 || gcyc[3] - gcyc[2] !== 18)) begin
      fails++;
      $display("FAIL b2b_gap: gaps %0d %0d %0d want 18", gcyc[1]-gcyc[0], gcyc[2]-gcyc[1], gcyc[3]-gcyc[2]);
    end
  endtask

  task automatic test_div_zero();
    int ea, ec, ra; logic [1:0] rv; logic [104:0] res; logic [6:0] ls; logic ov, zr, to;
    run_op(1, 53'd12345, 53'd0, ea, ec, ra, rv, res, ls, ov, zr, to);
    tests++;
    if (ec !== 0 || ra !== 1 || rv !== 2'b10) begin
      fails++;
      $display("FAIL dz_timing: ena_cnt=%0d resp_at=%0d strobe=%b want 0 1 10", ec, ra, rv);
    end
    tests++;
    if (res !== all_ones || ls !== 7'd0 || ov !== 1'b1 || zr !== 1'b0 || to !== 1'b0) begin
      fails++;
      $display("FAIL dz_data: res=%0h ls=%0d ov=%b zr=%b to=%b want ones 0 1 0 0", res, ls, ov, zr, to);
    end
  endtask

  task automatic test_timeout();
    int ea, ec, ra; logic [1:0] rv; logic [104:0] res; logic [6:0] ls; logic ov, zr, to;
    mdl_hang = 1'b1;
    run_op(0, 53'd500, 53'd3, ea, ec, ra, rv, res, ls, ov, zr, to);
    mdl_hang = 1'b0;
    tests++;
    if (ea !== 1 || ra !== 66 || rv !== 2'b01) begin
      fails++;
      $display("FAIL to_timing: ena_at=%0d resp_at=%0d strobe=%b want 1 66 01", ea, ra, rv);
    end
    tests++;
    if (res !== '0 || ov !== 1'b1 || to !== 1'b1) begin
      fails++;
      $display("FAIL to_data: res=%0h ov=%b to=%b want 0 1 1", res, ov, to);
    end
    @(negedge clk);
    req_valid = 2'b11; #1;
    tests++;
    if (req_ready !== 2'b10 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_next_grant: ready=%b busy=%b want 10 0", req_ready, busy);
    end
    req_valid = 2'b00; #1;
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    mdl_lat = 15;
    @(negedge clk);
    req_divident[52:0] = 53'h1234;
    req_divisor[52:0]  = 53'h10;
    req_valid = 2'b01;
    #1;
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || div_divident !== 53'h1234 || div_divisor !== 53'h10) begin
      fails++;
      $display("FAIL mid_wait_hold: busy=%b dvd=%0h dvs=%0h want 1 1234 10", busy, div_divident, div_divisor);
    end
    nrst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || div_ena !== 1'b0 || div_divident !== '0 ||
        div_divisor !== '0 || resp_result !== '0 || resp_overflow !== 1'b0 || resp_timeout !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outs: busy=%b resp=%b dvd=%0h res=%0h want all 0", busy, resp_valid, div_divident, resp_result);
    end
    nrst = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (resp_valid != 2'b00 || busy != 1'b0 || resp_result != '0) stray++;
    end
    tests++;
    if (stray !== 0) begin
      fails++;
      $display("FAIL mid_stale_rdy: %0d cycles with activity want 0", stray);
    end
  endtask

  task automatic test_rdy_edge();
    int ea, ec, ra; logic [1:0] rv; logic [104:0] res; logic [6:0] ls; logic ov, zr, to;
    @(negedge clk);
    spur_rdy = 1'b1;
    @(negedge clk);
    spur_rdy = 1'b0;
    tests++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || resp_result !== '0 || resp_lshift !== '0) begin
      fails++;
      $display("FAIL idle_rdy: busy=%b resp=%b res=%0h ls=%0d want 0 00 0 0", busy, resp_valid, resp_result, resp_lshift);
    end
    mdl_lat = 64;
    run_op(0, 53'd100, 53'd7, ea, ec, ra, rv, res, ls, ov, zr, to);
    mdl_lat = 15;
    tests++;
    if (ea !== 1 || ra !== 66 || rv !== 2'b01) begin
      fails++;
      $display("FAIL coinc_timing: ena_at=%0d resp_at=%0d strobe=%b want 1 66 01", ea, ra, rv);
    end
    tests++;
    if (res !== 105'd14 || ls !== 7'd5 || ov !== 1'b0 || zr !== 1'b0 || to !== 1'b0) begin
      fails++;
      $display("FAIL coinc_data: res=%0d ls=%0d ov=%b zr=%b to=%b want 14 5 0 0 0", res, ls, ov, zr, to);
    end
  endtask

  initial begin
    all_ones     = '1;
    nrst         = 1'b0;
    req_valid    = '0;
    req_divident = '0;
    req_divisor  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_div_zero();
    test_timeout();
    test_reset_mid();
    test_rdy_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
